// File: rtl/circular_shift_pkg.sv
// Shared types and constants for the iterative circular shifter.
package circular_shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } cs_state_t;

    localparam logic ROT_LEFT = 1'b1;

endpackage

// File: rtl/rotate_by_one_step.sv
// Combinational single-position rotator; left moves bits toward the MSB.
module rotate_by_one_step
    import circular_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic         left,
    output logic [N-1:0] y
);

    assign y = (left == ROT_LEFT) ? {x[N-2:0], x[N-1]} : {x[0], x[N-1:1]};

endmodule

// File: rtl/circular_shift_iterative.sv
// Multi-cycle rotator: accepts a word over valid/ready, rotates it one bit per
// clock by a run-time amount, and returns the result over valid/ready.
module circular_shift_iterative
    import circular_shift_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_amount,
    input  logic          up_left,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    cs_state_t     state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [SW-1:0] count_q, count_d;
    logic          left_q, left_d;
    logic [N-1:0]  step_y;

    rotate_by_one_step #(.N(N)) u_step (
        .x    (data_q),
        .left (left_q),
        .y    (step_y)
    );

    // Ready depends only on registered state and reset, never on down_ready.
    assign up_ready   = (state_q == IDLE) && !rst;
    assign down_valid = (state_q == DONE);
    assign down_data  = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        left_d  = left_q;
        case (state_q)
            IDLE: begin
                if (up_valid && up_ready) begin
                    data_d  = up_data;
                    left_d  = up_left;
                    count_d = up_amount;
                    state_d = (up_amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d  = step_y;
                count_d = count_q - 1'b1;
                if (count_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            left_q  <= left_d;
        end
    end

endmodule

// File: doc/circular_shift_iterative.md
Name: circular_shift_iterative

Overview:
- Multi-cycle circular shifter. It takes an N-bit word, a direction and a shift amount over a valid/ready input, then rotates the word one position per clock.
- It returns the result over a valid/ready output.
- It is the sequential neighbour of the fixed-amount combinational rotators: the same rotation function, but with a run-time amount and handshaked flow.
- Upstream is any valid/ready producer; downstream is any valid/ready consumer.

Parameters:
- N, 8, word width; must be a power of two and at least 2.
- SW, $clog2(N), width of the shift amount; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- up_valid  input  1  upstream offers a request.
- up_ready  output  1  block can accept a request.
- up_data  input  N  word to rotate.
- up_amount  input  SW  rotation distance, 0..N-1.
- up_left  input  1  1 = rotate left (toward MSB, MSB wraps to LSB); 0 = rotate right.
- down_valid  output  1  result available.
- down_ready  input  1  downstream accepts the result.
- down_data  output  N  rotated word.

Behaviour:
- Reset:
  - Asynchronous assertion forces state to IDLE, down_valid to 0, down_data to 0, and the internal count and direction to 0.
  - up_ready is 0 while rst is high.
  - Reset mid-shift or mid-DONE discards the word; no partial result is ever presented.
- States: IDLE, SHIFT, DONE.
- up_ready = (state == IDLE) && !rst. It is a registered-state decode with no combinational path from down_ready.
- IDLE:
  - On the edge where up_valid && up_ready, capture up_data, up_amount and up_left.
  - If amount == 0, go to DONE with down_data = up_data.
  - Otherwise go to SHIFT with count = amount.
- SHIFT:
  - Each edge rotates the working word by one position in the captured direction and decrements count.
  - On the edge where count == 1, perform the final rotation and go to DONE.
  - Upstream inputs are ignored in this state.
- DONE:
  - down_valid = 1.
  - down_data and down_valid stay stable until down_ready is 1 on an edge, then go to IDLE and drop down_valid.
  - There is no same-cycle re-accept: a new request is accepted at the earliest one cycle after the output handshake.
- Latency:
  - With accept at edge E0 and amount k, down_valid is high from edge E0+k; for k = 0, from edge E0.
  - Minimum request-to-request period is k+2 cycles (k = 0 counts as 2).
- Result:
  - Left by k equals {x[N-1-k:0], x[N-1:N-k]}.
  - Right by k equals {x[k-1:0], x[N-1:k]}.
  - k = 0 leaves the word unchanged.
- Width rules:
  - The count is SW bits and never underflows: SHIFT is entered only with a nonzero count.
  - Amounts ≥ N are not representable by construction.
- down_ready while down_valid is 0 has no effect.
- up_valid while up_ready is 0 is not consumed; upstream must hold it.

Decomposition:
- Package circular_shift_pkg:
  - typedef enum logic [1:0] { IDLE, SHIFT, DONE } cs_state_t.
  - localparam ROT_LEFT = 1'b1.
- One sub-module, rotate_by_one_step (parameter N): purely combinational, inputs x[N-1:0] and left, output y[N-1:0], rotating by exactly one position. It is instantiated once in the SHIFT datapath.
- The FSM, count and registers live in the top module.

Test Plan:
- Left rotation: N=8, up_data=8'b10110101, amount=3, left=1, down_ready=1 -> down_data=8'b10101101, with down_valid rising exactly 3 edges after the accept edge.
- Right rotation: same word, amount=3, left=0 -> down_data=8'b10110110. Then 8'b00000001, right by 7 -> 8'b00000010, with down_valid 7 edges after accept.
- Zero amount: up_data=8'b01100110, amount=0 -> down_data=8'b01100110, down_valid high the edge after accept, up_ready low while DONE.
- Backpressure: 8'b11100000 left 3 with down_ready held low for 5 cycles -> down_data=8'b00000111 stable and down_valid=1 throughout. up_ready stays 0, and a held up_valid with different data is not consumed. After down_ready=1, the block returns to IDLE, then accepts the held request.
- Reset mid-operation: 8'b11010001 left 5, assert rst after 2 shift edges -> down_valid=0 and down_data=0 immediately (asynchronously), up_ready=0 during rst. After release, up_ready=1 and 8'b11010001 left 3 yields 8'b10001110.
- Back-to-back random: 200 random words, amounts and directions with random down_ready -> every result matches the slice/concatenation reference model, in order, with none lost or duplicated.
